// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and default width for the MDU.
// Shared by the sequencer, its iteration core and the EX-side bus.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'd0;
  localparam md_op_t MD_MULTU = 3'd1;
  localparam md_op_t MD_DIV   = 3'd2;
  localparam md_op_t MD_DIVU  = 3'd3;
  localparam md_op_t MD_MFHI  = 3'd4;
  localparam md_op_t MD_MFLO  = 3'd5;
  localparam md_op_t MD_MTHI  = 3'd6;
  localparam md_op_t MD_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  function automatic logic op_is_arith(input md_op_t op);
    return !op[2];
  endfunction

  function automatic logic op_is_div(input md_op_t op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction

  function automatic logic op_is_signed(input md_op_t op);
    return op == MD_MULT || op == MD_DIV;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage to MDU request/response bundle.
// master = EX side, slave = the MDU sequencer.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             md_valid;
  md_op_t           md_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output md_valid, md_op, op_a, op_b,
    input  stall, busy, done, hi, lo, rd_data
  );

  modport slave (
    input  md_valid, md_op, op_a, op_b,
    output stall, busy, done, hi, lo, rd_data
  );

endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one shift-add (MUL) or restoring-subtract (DIV)
// step on the {acc, q} pair; purely combinational.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] q_nx
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
    shl  = {acc, q[WIDTH-1]};
    diff = {1'b0, shl} - {2'b00, d};
    // diff fits in WIDTH bits exactly when shl >= d
    ge   = ~|diff[WIDTH+1:WIDTH];
    if (div) begin
      acc_nx = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
      q_nx   = {q[WIDTH-2:0], ge};
    end else begin
      acc_nx = sum[WIDTH:1];
      q_nx   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/DIV controller and HI/LO owner.
// Define MDU_EARLY_TERM_EN to end MUL once the multiplier is exhausted.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave md
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e state;
  state_e state_nx;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   acc_nx;
  logic [WIDTH-1:0]   q_nx;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;
  logic [WIDTH-1:0]   rd;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod;

  logic is_div;
  logic neg_res;
  logic neg_rem;
  logic dz;
  logic done;
  logic busy;
  logic accept;
  logic start;
  logic div_op;
  logic sgn;
  logic last;

  assign busy   = state != IDLE;
  assign accept = md.md_valid && !busy;
  assign start  = accept && op_is_arith(md.md_op);
  assign div_op = op_is_div(md.md_op);
  assign sgn    = op_is_signed(md.md_op);

  assign abs_a = (sgn && md.op_a[WIDTH-1]) ? -md.op_a : md.op_a;
  assign abs_b = (sgn && md.op_b[WIDTH-1]) ? -md.op_b : md.op_b;

  mdu_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .div   (state == DIV),
    .acc   (acc),
    .q     (q),
    .d     (d),
    .acc_nx(acc_nx),
    .q_nx  (q_nx)
  );

`ifdef MDU_EARLY_TERM_EN
  // unconsumed multiplier bits sit below the product bits shifted into q
  always_comb begin
    last = cnt == CW'(WIDTH - 1);
    if (state == MUL)
      last = ((q >> 1) & ({WIDTH{1'b1}} >> (cnt + 1'b1))) == '0;
  end

  assign prod_raw = {acc, q} >> (CW'(WIDTH) - cnt);
`else
  assign last     = cnt == CW'(WIDTH - 1);
  assign prod_raw = {acc, q};
`endif

  // a zero divisor leaves q all-ones and acc = |a|; only q skips negation
  assign prod   = neg_res ? -prod_raw : prod_raw;
  assign quo    = dz ? '1 : (neg_res ? -q : q);
  assign rem    = neg_rem ? -acc : acc;
  assign hi_fix = is_div ? rem : prod[2*WIDTH-1:WIDTH];
  assign lo_fix = is_div ? quo : prod[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = div_op ? DIV : MUL;
      MUL:  if (last) state_nx = FIX;
      DIV:  if (last) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      q       <= '0;
      d       <= '0;
      hi      <= '0;
      lo      <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              start: begin
                cnt     <= '0;
                acc     <= '0;
                q       <= div_op ? abs_a : abs_b;
                d       <= div_op ? abs_b : abs_a;
                is_div  <= div_op;
                neg_res <= sgn && (md.op_a[WIDTH-1] ^ md.op_b[WIDTH-1]);
                neg_rem <= sgn && md.op_a[WIDTH-1];
                dz      <= div_op && md.op_b == '0;
              end
              md.md_op == MD_MTHI: hi <= md.op_a;
              md.md_op == MD_MTLO: lo <= md.op_a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          acc <= acc_nx;
          q   <= q_nx;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi   <= hi_fix;
          lo   <= lo_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      md.md_op == MD_MFHI: rd = hi;
      md.md_op == MD_MFLO: rd = lo;
      default: ;
    endcase
  end

  assign md.stall   = md.md_valid && busy;
  assign md.busy    = busy;
  assign md.done    = done;
  assign md.hi      = hi;
  assign md.lo      = lo;
  assign md.rd_data = rd;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit controller with architectural HI/LO registers for the 5-stage MIPS pipeline; sits beside the EX-stage ALU.
- Decoded MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO ops arrive from EX. The block sequences a WIDTH-iteration shift-add / restoring-divide engine and raises a stall request to the hazard logic while HI/LO are not yet valid.

Parameters:
- WIDTH, 32, operand/HI/LO width; also the iteration count.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; all state cleared on assertion.
- md_valid  in  1  EX holds a valid, unflushed MDU-class instruction.
- md_op  in  3  op code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- op_a  in  WIDTH  rs value; the dividend for divides.
- op_b  in  WIDTH  rt value; the divisor for divides.
- stall  out  1  pipeline must freeze IF/ID/EX this cycle.
- busy  out  1  engine in MUL, DIV or FIX.
- done  out  1  one-cycle pulse after HI/LO update from MUL/DIV.
- hi  out  WIDTH  current HI.
- lo  out  WIDTH  current LO.
- rd_data  out  WIDTH  combinational hi (MFHI) or lo (MFLO); 0 for other ops.

Behaviour:
- Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, stall=0, iteration counter 0.
- stall is combinational: md_valid && busy, whatever md_op is. Stalled inputs are held stable by the pipeline and re-presented every cycle.
- An op is accepted when md_valid && !busy.
- MTHI / MTLO:
  - Write op_a into hi / lo at the accepting edge.
  - No busy, no done.
- MFHI / MFLO:
  - rd_data is valid in the same cycle.
  - No state change.
- MULT / MULTU / DIV / DIVU start:
  - Acceptance edge E0: capture operands, go IDLE -> MUL or DIV, counter = 0.
  - Signed ops latch |op_a| and |op_b| plus negate flags.
  - Result sign (MULT, DIV quotient) = sign(a) XOR sign(b); DIV remainder sign = sign(a).
- MUL / DIV states: one iteration per cycle for WIDTH cycles, then go to FIX.
  - MUL: shift-add into a 2*WIDTH accumulator.
  - DIV: restoring step producing one quotient bit.
- FIX:
  - Applies two's-complement negation per the flags.
  - At the leaving edge: MUL writes {hi,lo} = 2*WIDTH product; DIV writes lo = quotient, hi = remainder.
  - State -> IDLE; done=1 for the following cycle only.
- Latency:
  - busy is high from E0+1 through E_WIDTH+1 (WIDTH+1 cycles).
  - A dependent MFHI issued the cycle after MULT stalls WIDTH+1 cycles (33 at default).
- In the done cycle busy=0, so a new op is accepted in that same cycle.
- Divide by zero (op_b==0, signed or unsigned):
  - Still takes full latency.
  - lo = all-ones, hi = original op_a; no negation applied.
- DIV of most-negative by -1: lo = 0x8000_0000, hi = 0; no trap.
- Reset mid-operation: immediate return to IDLE; hi/lo = 0; the in-flight result is discarded.
- Arithmetic: |x| computed in WIDTH+1 bits so that |-2^(WIDTH-1)| is representable; all internal adds are unsigned.

Optional Feature:
- MDU_EARLY_TERM_EN defined:
  - MUL leaves for FIX as soon as the remaining multiplier bits are all zero, after at least 1 iteration.
  - Latency becomes (index of highest set bit of |op_b|)+1 iterations + 1 FIX; multiplier 0 takes 1 iteration.
  - The result must be identical to the full run.
  - DIV is unaffected.
- Undefined: fixed WIDTH iterations for all ops.

Decomposition:
- Package mdu_pkg: md_op encoding constants (MD_MULT..MD_MTLO), state enum (IDLE, MUL, DIV, FIX), WIDTH default.
- One sub-module, mdu_iter_core: a combinational single-iteration step (shift-add or restore-subtract) on {acc, operand}. The sequencer owns the counter, FSM, sign fix and HI/LO.

Test Plan:
- MULT a=-3 (0xFFFF_FFFD), b=7 -> stall 33 cycles for a back-to-back MFLO; then hi=0xFFFF_FFFF, lo=0xFFFF_FFEB, done pulses once.
- MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001 after 33 busy cycles.
- DIV a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIVU 7/0 -> lo=0xFFFF_FFFF, hi=7.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0; MTHI 0x1234 while idle -> hi=0x1234 next cycle, no stall.
- Assert reset at iteration 10 of a MULT -> busy=0, hi=lo=0 immediately; a subsequent MFHI returns 0 without stall.
- MDU_EARLY_TERM_EN: MULTU 5 x 3 -> busy 3 cycles (2 iterations + FIX), lo=15; DIV latency still 33.
